// File: rtl/m_vmem_rect_fill.sv
`default_nettype none
// ============================================================================
// Module      : m_vmem_rect_fill
// Description : Rectangle-fill engine that writes one RGB565 pixel per cycle
//               into VMEM in raster order. Optional macro VMEM_FILL_CLIP_EN
//               swaps and clamps corners instead of rejecting bad commands.
// Revision    : 1.0 - initial release
// ============================================================================
module m_vmem_rect_fill #(
    parameter int SCREEN_W = 240,
    parameter int SCREEN_H = 240,
    parameter int ADDRW    = 16
) (
    input  logic             w_clk,
    input  logic             w_rst_n,
    input  logic             w_cmd_valid,
    output logic             w_cmd_ready,
    input  logic [7:0]       w_x0,
    input  logic [7:0]       w_y0,
    input  logic [7:0]       w_x1,
    input  logic [7:0]       w_y1,
    input  logic [15:0]      w_color,
    input  logic             w_stall,
    output logic             w_we,
    output logic [ADDRW-1:0] w_waddr,
    output logic [15:0]      w_wdata,
    output logic             w_busy,
    output logic             w_done,
    output logic             w_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [8:0] c_scr_w = 9'(SCREEN_W);
    localparam logic [8:0] c_scr_h = 9'(SCREEN_H);
`ifdef VMEM_FILL_CLIP_EN
    localparam logic [7:0] c_x_max = 8'(SCREEN_W - 1);
    localparam logic [7:0] c_y_max = 8'(SCREEN_H - 1);
`endif

    state_t           r_state;
    logic [7:0]       r_cx;
    logic [7:0]       r_cy;
    logic [7:0]       r_x0;
    logic [7:0]       r_x1;
    logic [7:0]       r_y1;
    logic [15:0]      r_color;
    logic             r_last;
    logic             r_we;
    logic [ADDRW-1:0] r_waddr;
    logic [15:0]      r_wdata;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [7:0]  w_nx0;
    logic [7:0]  w_nx1;
    logic [7:0]  w_ny0;
    logic [7:0]  w_ny1;
    logic        w_cmd_ok;
    logic [7:0]  w_src_cx;
    logic [7:0]  w_src_cy;
    logic [7:0]  w_src_x0;
    logic [7:0]  w_src_x1;
    logic [7:0]  w_src_y1;
    logic [15:0] w_src_color;
    logic        w_row_end;
    logic        w_at_end;
    logic [7:0]  w_step_cx;
    logic [7:0]  w_step_cy;
    logic        w_accept;
    logic        w_issue;

    // Command normalisation: either sanitise the corners or judge legality.
    always_comb begin
        w_nx0    = w_x0;
        w_nx1    = w_x1;
        w_ny0    = w_y0;
        w_ny1    = w_y1;
        w_cmd_ok = 1'b1;
`ifdef VMEM_FILL_CLIP_EN
        if (w_x0 > w_x1) begin
            w_nx0 = w_x1;
            w_nx1 = w_x0;
        end
        if (w_y0 > w_y1) begin
            w_ny0 = w_y1;
            w_ny1 = w_y0;
        end
        if ({1'b0, w_nx0} >= c_scr_w) w_nx0 = c_x_max;
        if ({1'b0, w_nx1} >= c_scr_w) w_nx1 = c_x_max;
        if ({1'b0, w_ny0} >= c_scr_h) w_ny0 = c_y_max;
        if ({1'b0, w_ny1} >= c_scr_h) w_ny1 = c_y_max;
`else
        w_cmd_ok = (w_x0 <= w_x1) && (w_y0 <= w_y1) &&
                   ({1'b0, w_x1} < c_scr_w) && ({1'b0, w_y1} < c_scr_h);
`endif
    end

    // The pixel being issued comes straight from the command on the accept
    // edge, so the first write lands in the cycle right after acceptance.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_src_cx    = w_nx0;
            w_src_cy    = w_ny0;
            w_src_x0    = w_nx0;
            w_src_x1    = w_nx1;
            w_src_y1    = w_ny1;
            w_src_color = w_color;
        end else begin
            w_src_cx    = r_cx;
            w_src_cy    = r_cy;
            w_src_x0    = r_x0;
            w_src_x1    = r_x1;
            w_src_y1    = r_y1;
            w_src_color = r_color;
        end
        w_row_end = (w_src_cx == w_src_x1);
        w_at_end  = w_row_end && (w_src_cy == w_src_y1);
        w_step_cx = w_row_end ? w_src_x0 : w_src_cx + 8'd1;
        w_step_cy = w_row_end ? w_src_cy + 8'd1 : w_src_cy;
    end

    assign w_accept = (r_state == S_IDLE) && w_cmd_valid;
    assign w_issue  = (w_accept && w_cmd_ok) || ((r_state == S_FILL) && !r_last);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
            r_cx    <= 8'd0;
            r_cy    <= 8'd0;
            r_x0    <= 8'd0;
            r_x1    <= 8'd0;
            r_y1    <= 8'd0;
            r_color <= 16'd0;
            r_last  <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= 16'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_busy  <= 1'b1;
                        r_color <= w_color;
                        r_x0    <= w_nx0;
                        r_x1    <= w_nx1;
                        r_y1    <= w_ny1;
                        r_last  <= 1'b0;
                        if (w_cmd_ok) begin
                            r_state <= S_FILL;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (r_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_last  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A stalled cycle parks the cursor on the pending pixel and keeps
            // the last address/data on the bus.
            if (w_issue) begin
                if (w_stall) begin
                    r_cx <= w_src_cx;
                    r_cy <= w_src_cy;
                end else begin
                    r_we    <= 1'b1;
                    r_waddr <= ADDRW'({w_src_cy, w_src_cx});
                    r_wdata <= w_src_color;
                    r_cx    <= w_step_cx;
                    r_cy    <= w_step_cy;
                    r_last  <= w_at_end;
                end
            end
        end
    end

    assign w_cmd_ready = (r_state == S_IDLE);
    assign w_we        = r_we;
    assign w_waddr     = r_waddr;
    assign w_wdata     = r_wdata;
    assign w_busy      = r_busy;
    assign w_done      = r_done;
    assign w_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_m_vmem_rect_fill.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_vmem_rect_fill
// Description : Self-checking bench for m_vmem_rect_fill (vector table,
//               directed corner sequences, randomized commands vs. model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_vmem_rect_fill;

    localparam int SW = 240;
    localparam int SH = 240;

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic        w_cmd_valid = 1'b0;
    logic        w_cmd_ready;
    logic [7:0]  w_x0 = 8'd0;
    logic [7:0]  w_y0 = 8'd0;
    logic [7:0]  w_x1 = 8'd0;
    logic [7:0]  w_y1 = 8'd0;
    logic [15:0] w_color = 16'd0;
    logic        w_stall = 1'b0;
    logic        w_we;
    logic [15:0] w_waddr;
    logic [15:0] w_wdata;
    logic        w_busy;
    logic        w_done;
    logic        w_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 w_clk = ~w_clk;

    m_vmem_rect_fill #(.SCREEN_W(SW), .SCREEN_H(SH), .ADDRW(16)) u_dut (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .w_cmd_valid (w_cmd_valid),
        .w_cmd_ready (w_cmd_ready),
        .w_x0        (w_x0),
        .w_y0        (w_y0),
        .w_x1        (w_x1),
        .w_y1        (w_y1),
        .w_color     (w_color),
        .w_stall     (w_stall),
        .w_we        (w_we),
        .w_waddr     (w_waddr),
        .w_wdata     (w_wdata),
        .w_busy      (w_busy),
        .w_done      (w_done),
        .w_err       (w_err)
    );

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%04h required=0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    // Issue one command and follow it to completion against the reference:
    // the expected pixel list is built from the rectangle rules, and each
    // cycle either writes the next pixel, stalls, or (once the list is empty)
    // shows the done pulse.
    task automatic run_cmd(input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] x1, input logic [7:0] y1,
                           input logic [15:0] col, input logic [63:0] smask,
                           input int spct, output int n_wr, output int done_cyc,
                           output logic err_seen);
        int          ax0 = int'(x0);
        int          ax1 = int'(x1);
        int          ay0 = int'(y0);
        int          ay1 = int'(y1);
        int          t;
        bit          legal;
        logic [15:0] q[$];
        logic [15:0] last_addr = 16'd0;
        bit          have_last = 0;
        bit          st = 0;
        int          cyc = 1;
        int          stalls = 0;
        int          bound;
`ifdef VMEM_FILL_CLIP_EN
        if (ax0 > ax1) begin t = ax0; ax0 = ax1; ax1 = t; end
        if (ay0 > ay1) begin t = ay0; ay0 = ay1; ay1 = t; end
        if (ax0 >= SW) ax0 = SW - 1;
        if (ax1 >= SW) ax1 = SW - 1;
        if (ay0 >= SH) ay0 = SH - 1;
        if (ay1 >= SH) ay1 = SH - 1;
        legal = 1;
`else
        t = 0;
        legal = (ax0 <= ax1) && (ay0 <= ay1) && (ax1 < SW) && (ay1 < SH);
`endif
        if (legal)
            for (int y = ay0; y <= ay1; y++)
                for (int x = ax0; x <= ax1; x++)
                    q.push_back({y[7:0], x[7:0]});
        bound    = q.size() + 5;
        n_wr     = 0;
        done_cyc = -1;
        err_seen = 1'b0;

        chk_b("ready_before_cmd", w_cmd_ready, 1'b1);
        w_x0 = x0; w_y0 = y0; w_x1 = x1; w_y1 = y1; w_color = col;
        w_cmd_valid = 1'b1;
        w_stall = 1'b0;
        tick();
        w_cmd_valid = 1'b0;
        w_x0 = 8'($urandom); w_y0 = 8'($urandom);
        w_x1 = 8'($urandom); w_y1 = 8'($urandom);
        w_color = 16'($urandom);

        while (1) begin
            if (cyc > bound + stalls) begin
                chk_b("fill_timeout", 1'b1, 1'b0);
                break;
            end
            chk_b("busy", w_busy, 1'b1);
            chk_b("ready_while_busy", w_cmd_ready, 1'b0);
            if (q.size() == 0) begin
                chk_b("done", w_done, 1'b1);
                chk_b("err", w_err, !legal);
                chk_b("we_in_done", w_we, 1'b0);
                done_cyc = cyc;
                err_seen = w_err;
                break;
            end
            chk_b("done_early", w_done, 1'b0);
            if (st) begin
                chk_b("we_stalled", w_we, 1'b0);
                if (have_last) chk_w("addr_hold", w_waddr, last_addr);
            end else begin
                chk_b("we", w_we, 1'b1);
                chk_w("waddr", w_waddr, q[0]);
                chk_w("wdata", w_wdata, col);
                last_addr = q.pop_front();
                have_last = 1;
            end
            if (w_we) n_wr++;
            st = ((cyc < 64) ? smask[cyc[5:0]] : 1'b0) | ($urandom_range(99) < spct);
            if (st) stalls++;
            w_stall = st;
            tick();
            cyc++;
        end
        w_stall = 1'b0;
        tick();
        chk_b("done_clear", w_done, 1'b0);
        chk_b("err_clear", w_err, 1'b0);
        chk_b("busy_clear", w_busy, 1'b0);
        chk_b("ready_back", w_cmd_ready, 1'b1);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  x0, y0, x1, y1;
        logic [15:0] col;
        logic [63:0] smask;
        int          exp_wr;
        int          exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_wr;
        int          dc;
        logic        e;
        logic [15:0] a_exp[4];

        vecs[0] = '{"full_screen", 8'd0, 8'd0, 8'd239, 8'd239, 16'hF800, 64'h0, 57600, 57601, 1'b0};
        vecs[1] = '{"single_pixel", 8'd5, 8'd7, 8'd5, 8'd7, 16'h07E0, 64'h0, 1, 2, 1'b0};
        vecs[2] = '{"stall_3", 8'd2, 8'd3, 8'd3, 8'd4, 16'h001F, 64'h1C, 4, 8, 1'b0};
        vecs[4] = '{"wrap_3x3", 8'd3, 8'd1, 8'd5, 8'd3, 16'hC0DE, 64'h0, 9, 10, 1'b0};
        vecs[6] = '{"corner_pixel", 8'd239, 8'd239, 8'd239, 8'd239, 16'hAAAA, 64'h0, 1, 2, 1'b0};
`ifdef VMEM_FILL_CLIP_EN
        vecs[3] = '{"illegal_swap", 8'd10, 8'd0, 8'd5, 8'd0, 16'hFFFF, 64'h0, 6, 7, 1'b0};
        vecs[5] = '{"overrange_x", 8'd230, 8'd5, 8'd250, 8'd5, 16'h1111, 64'h0, 10, 11, 1'b0};
`else
        vecs[3] = '{"illegal_swap", 8'd10, 8'd0, 8'd5, 8'd0, 16'hFFFF, 64'h0, 0, 1, 1'b1};
        vecs[5] = '{"overrange_x", 8'd230, 8'd5, 8'd250, 8'd5, 16'h1111, 64'h0, 0, 1, 1'b1};
`endif

        // Reset state
        tick();
        tick();
        chk_b("rst_we", w_we, 1'b0);
        chk_w("rst_waddr", w_waddr, 16'h0000);
        chk_w("rst_wdata", w_wdata, 16'h0000);
        chk_b("rst_busy", w_busy, 1'b0);
        chk_b("rst_done", w_done, 1'b0);
        chk_b("rst_err", w_err, 1'b0);
        w_rst_n = 1'b1;
        tick();
        chk_b("rst_ready", w_cmd_ready, 1'b1);

        foreach (vecs[i]) begin
            run_cmd(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].col,
                    vecs[i].smask, 0, n_wr, dc, e);
            chk_i({vecs[i].name, "_writes"}, n_wr, vecs[i].exp_wr);
            chk_i({vecs[i].name, "_done_cycle"}, dc, vecs[i].exp_done);
            chk_b({vecs[i].name, "_err"}, e, vecs[i].exp_err);
        end

        // Second command held during a fill is taken only after the done cycle
        a_exp = '{16'h0000, 16'h0001, 16'h0100, 16'h0101};
        w_x0 = 8'd0; w_y0 = 8'd0; w_x1 = 8'd1; w_y1 = 8'd1; w_color = 16'h1234;
        w_cmd_valid = 1'b1;
        tick();
        w_x0 = 8'd9; w_y0 = 8'd9; w_x1 = 8'd9; w_y1 = 8'd9; w_color = 16'hABCD;
        for (int c = 1; c <= 5; c++) begin
            chk_b("busy_seq_ready", w_cmd_ready, 1'b0);
            if (c <= 4) begin
                chk_b("busy_seq_we", w_we, 1'b1);
                chk_w("busy_seq_addr", w_waddr, a_exp[c-1]);
                chk_w("busy_seq_data", w_wdata, 16'h1234);
            end else begin
                chk_b("busy_seq_done", w_done, 1'b1);
            end
            tick();
        end
        chk_b("busy_seq_ready_after_done", w_cmd_ready, 1'b1);
        chk_b("busy_seq_not_taken", w_we, 1'b0);
        tick();
        w_cmd_valid = 1'b0;
        chk_b("busy_seq_b_we", w_we, 1'b1);
        chk_w("busy_seq_b_addr", w_waddr, 16'h0909);
        chk_w("busy_seq_b_data", w_wdata, 16'hABCD);
        tick();
        chk_b("busy_seq_b_done", w_done, 1'b1);
        chk_b("busy_seq_b_err", w_err, 1'b0);
        tick();
        chk_b("busy_seq_idle", w_cmd_ready, 1'b1);

        // Asynchronous reset in the middle of a full-screen fill
        w_x0 = 8'd0; w_y0 = 8'd0; w_x1 = 8'd239; w_y1 = 8'd239; w_color = 16'hF800;
        w_cmd_valid = 1'b1;
        tick();
        w_cmd_valid = 1'b0;
        for (int i = 1; i < 100; i++) tick();
        chk_b("pre_reset_we", w_we, 1'b1);
        chk_w("pre_reset_addr", w_waddr, 16'h0063);
        #2;
        w_rst_n = 1'b0;
        #1;
        chk_b("async_rst_we", w_we, 1'b0);
        chk_b("async_rst_busy", w_busy, 1'b0);
        chk_w("async_rst_addr", w_waddr, 16'h0000);
        tick();
        tick();
        w_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_b("post_rst_we", w_we, 1'b0);
            chk_b("post_rst_done", w_done, 1'b0);
            chk_b("post_rst_ready", w_cmd_ready, 1'b1);
        end

        // Randomized commands with random stalls
        for (int k = 0; k < 16; k++) begin
            logic [7:0] rx0, ry0, rx1, ry1, tmp;
            rx0 = 8'($urandom_range(0, 255));
            ry0 = 8'($urandom_range(0, 255));
            rx1 = rx0 + 8'($urandom_range(0, 7));
            ry1 = ry0 + 8'($urandom_range(0, 7));
            if ($urandom_range(3) == 0) begin tmp = rx0; rx0 = rx1; rx1 = tmp; end
            if ($urandom_range(3) == 0) begin tmp = ry0; ry0 = ry1; ry1 = tmp; end
            run_cmd(rx0, ry0, rx1, ry1, 16'($urandom), 64'h0, 30, n_wr, dc, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
